// File: rtl/mc_datapath.sv
// Multi-cycle RV32I-subset datapath: FETCH/DECODE/EXEC/MEM/WB sequencing over a
// single shared instruction/data memory port with a ready handshake.
module mc_datapath #(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [3:0]      status,
    output logic [XLEN-1:0] pc,
    output logic            halt
);
    localparam int         RW    = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [5:0] NREG6 = 6'(NREG);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT} alu_op_t;

    state_t          state;
    logic [31:0]     ir;
    logic [XLEN-1:0] a, b, imm, res, mdr;
    logic [XLEN-1:0] regs [NREG];

    logic [6:0] opcode, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    logic    is_r, is_addi, is_lw, is_sw, is_br, is_ecall, bad_enc, bad_idx;
    logic    use_rs2, use_rd;
    alu_op_t alu_op;

    // Instruction decode from the latched IR; also flags out-of-range register fields
    always_comb begin
        is_r = 1'b0; is_addi = 1'b0; is_lw = 1'b0; is_sw = 1'b0; is_br = 1'b0;
        is_ecall = 1'b0; bad_enc = 1'b0; alu_op = OP_ADD;
        case (opcode)
            7'h33: begin
                is_r = 1'b1;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'b000:  alu_op = OP_ADD;
                        3'b111:  alu_op = OP_AND;
                        3'b110:  alu_op = OP_OR;
                        3'b100:  alu_op = OP_XOR;
                        3'b010:  alu_op = OP_SLT;
                        default: bad_enc = 1'b1;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'b000) begin
                    alu_op = OP_SUB;
                end else begin
                    bad_enc = 1'b1;
                end
            end
            7'h13: begin is_addi = 1'b1; bad_enc = (f3 != 3'b000); end
            7'h03: begin is_lw = 1'b1; bad_enc = (f3 != 3'b010); end
            7'h23: begin is_sw = 1'b1; bad_enc = (f3 != 3'b010); end
            7'h63: begin is_br = 1'b1; alu_op = OP_SUB; bad_enc = (f3[2:1] != 2'b00); end
            7'h73: is_ecall = 1'b1;
            default: bad_enc = 1'b1;
        endcase
        // Only the fields a format actually uses are range-checked; I-type imm bits overlap rs2
        use_rs2 = is_r | is_sw | is_br;
        use_rd  = is_r | is_addi | is_lw;
        bad_idx = ({1'b0, rs1} >= NREG6) || (use_rs2 && {1'b0, rs2} >= NREG6) ||
                  (use_rd && {1'b0, rd} >= NREG6);
    end

    logic [XLEN-1:0] op_b, bb, alu_res, flag_src;
    logic [XLEN:0]   sum;
    logic            sub, ovf, fn, fz, fc, fv;

    // ALU: shared adder does ADD/SUB/compare; SLT and branches reuse the subtraction flags
    always_comb begin
        op_b     = is_addi ? imm : b;
        sub      = (alu_op == OP_SUB) || (alu_op == OP_SLT);
        bb       = sub ? ~op_b : op_b;
        sum      = {1'b0, a} + {1'b0, bb} + {{XLEN{1'b0}}, sub};
        ovf      = (a[XLEN-1] == bb[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
        alu_res  = sum[XLEN-1:0];
        fc       = sum[XLEN];
        fv       = ovf;
        case (alu_op)
            OP_AND:  begin alu_res = a & op_b; fc = 1'b0; fv = 1'b0; end
            OP_OR:   begin alu_res = a | op_b; fc = 1'b0; fv = 1'b0; end
            OP_XOR:  begin alu_res = a ^ op_b; fc = 1'b0; fv = 1'b0; end
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, sum[XLEN-1] ^ ovf};
            default: ;
        endcase
        flag_src = (alu_op == OP_SLT) ? sum[XLEN-1:0] : alu_res;
        fn       = flag_src[XLEN-1];
        fz       = (flag_src == '0);
    end

    // Memory port decoded from state; forced quiet while reset is held so an abort is immediate
    always_comb begin
        mem_req   = rst && (state == S_FETCH || state == S_MEM);
        mem_we    = rst && (state == S_MEM) && is_sw;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst && state == S_FETCH) mem_addr = pc;
        if (rst && state == S_MEM) begin
            mem_addr  = res;
            mem_wdata = b;
        end
    end

    // Instruction sequencer: owns PC, register file, IR/operand latches, status and halt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            imm    <= '0;
            res    <= '0;
            mdr    <= '0;
            status <= '0;
            halt   <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir    <= mem_rdata[31:0];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a <= regs[rs1[RW-1:0]];
                    b <= regs[rs2[RW-1:0]];
                    if (is_sw)
                        imm <= {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
                    else if (is_br)
                        imm <= {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
                    else
                        imm <= {{(XLEN-12){ir[31]}}, ir[31:20]};
                    if (bad_enc || bad_idx || is_ecall) begin
                        halt  <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_br) begin
                        status <= {fn, fz, fc, fv};
                        pc     <= ((f3[0] ? !fz : fz)) ? pc + imm : pc + XLEN'(4);
                        state  <= S_FETCH;
                    end else if (is_lw || is_sw) begin
                        res   <= a + imm;
                        state <= S_MEM;
                    end else begin
                        res    <= alu_res;
                        status <= {fn, fz, fc, fv};
                        state  <= S_WB;
                    end
                end
                S_MEM: if (mem_ready) begin
                    if (is_sw) begin
                        pc    <= pc + XLEN'(4);
                        state <= S_FETCH;
                    end else begin
                        mdr   <= mem_rdata;
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    if (rd != 5'd0) regs[rd[RW-1:0]] <= is_lw ? mdr : res;
                    pc    <= pc + XLEN'(4);
                    state <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: begin
                    halt  <= 1'b1;
                    state <= S_HALT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: small programs in a TB memory, scoreboard of expected
// memory transactions (fetch PC, CPI, status, store data) checked at each handshake.
module tb_mc_datapath;
    localparam int          XLEN = 32;
    localparam int          NREG = 16;
    localparam logic [31:0] RPC  = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, halt;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic [3:0]  status;
    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr[11:2]];

    mc_datapath #(.XLEN(XLEN), .NREG(NREG), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .status(status), .pc(pc), .halt(halt)
    );

    typedef struct {
        logic        fetch;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        int          cpi;
        logic        cks;
        logic [3:0]  st;
    } txn_t;

    txn_t sbq[$];
    int   n_chk = 0, n_err = 0, cyc = 0, cnt = 0, last_fetch = 0;
    bit   strict = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {im, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [2:0] f3,
                                          input logic [4:0] rs2, input logic [4:0] rs1);
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
    endfunction

    task automatic ex_fetch(input logic [31:0] a, input int cpi, input int st);
        txn_t e;
        e.fetch = 1'b1; e.we = 1'b0; e.addr = a; e.wdata = '0; e.waits = 0;
        e.cpi = cpi; e.cks = (st >= 0); e.st = 4'(st);
        sbq.push_back(e);
    endtask
    task automatic ex_mem(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input int waits);
        txn_t e;
        e.fetch = 1'b0; e.we = we; e.addr = a; e.wdata = d; e.waits = waits;
        e.cpi = 0; e.cks = 1'b0; e.st = '0;
        sbq.push_back(e);
    endtask

    // Memory responder + scoreboard: decides mem_ready for the coming edge and checks the txn
    always @(negedge clk) begin
        txn_t e;
        if (!rst) begin
            cnt = 0;
            mem_ready = 1'b0;
        end else begin
            cyc++;
            if (!mem_req) begin
                mem_ready = 1'b0;
            end else if (sbq.size() == 0) begin
                mem_ready = 1'b1;
                if (strict) chk("unexpected_txn", sbq.size(), 1);
            end else if (cnt < sbq[0].waits) begin
                mem_ready = 1'b0;
                cnt++;
                chk("hold_addr", mem_addr, sbq[0].addr);
                chk("hold_we", mem_we, sbq[0].we);
                if (sbq[0].we) chk("hold_wdata", mem_wdata, sbq[0].wdata);
            end else begin
                e = sbq.pop_front();
                mem_ready = 1'b1;
                cnt = 0;
                chk("addr", mem_addr, e.addr);
                chk("we", mem_we, e.we);
                if (e.we) begin
                    chk("wdata", mem_wdata, e.wdata);
                    mem[mem_addr[11:2]] = mem_wdata;
                end
                if (e.fetch) begin
                    chk("pc", pc, e.addr);
                    if (e.cpi != 0) chk("cpi", cyc - last_fetch, e.cpi);
                    last_fetch = cyc;
                    if (e.cks) chk("status", status, e.st);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic reset_on();
        rst = 1'b0;
        strict = 1'b0;
        sbq.delete();
        repeat (2) tick();
    endtask
    task automatic release_rst();
        strict = 1'b1;
        rst = 1'b1;
        #1;
        chk("boot_req", mem_req, 1);
        chk("boot_addr", mem_addr, RPC);
        chk("boot_we", mem_we, 0);
    endtask
    task automatic wait_empty(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("sb_drain", sbq.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // Boot state and arithmetic / memory / logic program
        reset_on();
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_pc", pc, RPC);
        chk("rst_halt", halt, 0);
        chk("rst_status", status, 0);
        mem[32'h100 >> 2] = enc_i(12'h7FF, 0, 3'b000, 1, 7'h13); ex_fetch(32'h100, 0, -1);
        mem[32'h104 >> 2] = enc_r(7'h00, 1, 1, 3'b000, 2);       ex_fetch(32'h104, 4, 4'b0000);
        mem[32'h108 >> 2] = enc_r(7'h20, 0, 0, 3'b000, 3);       ex_fetch(32'h108, 4, 4'b0000);
        mem[32'h10C >> 2] = enc_i(12'hFFF, 0, 3'b000, 4, 7'h13); ex_fetch(32'h10C, 4, 4'b0110);
        mem[32'h110 >> 2] = enc_r(7'h00, 4, 4, 3'b000, 5);       ex_fetch(32'h110, 4, 4'b1000);
        mem[32'h114 >> 2] = enc_s(12'd8, 2, 0);                  ex_fetch(32'h114, 4, 4'b1010);
        ex_mem(1'b1, 32'd8, 32'h0000_0FFE, 3);
        mem[32'h118 >> 2] = enc_i(12'd8, 0, 3'b010, 6, 7'h03);   ex_fetch(32'h118, 7, 4'b1010);
        ex_mem(1'b0, 32'd8, 32'h0, 3);
        mem[32'h11C >> 2] = enc_s(12'd12, 6, 0);                 ex_fetch(32'h11C, 8, 4'b1010);
        ex_mem(1'b1, 32'd12, 32'h0000_0FFE, 0);
        mem[32'h120 >> 2] = enc_s(12'd16, 5, 0);                 ex_fetch(32'h120, 4, -1);
        ex_mem(1'b1, 32'd16, 32'hFFFF_FFFE, 0);
        mem[32'h124 >> 2] = enc_i(12'd5, 0, 3'b000, 0, 7'h13);   ex_fetch(32'h124, 4, -1);
        mem[32'h128 >> 2] = enc_s(12'd20, 0, 0);                 ex_fetch(32'h128, 4, 4'b0000);
        ex_mem(1'b1, 32'd20, 32'h0, 0);
        mem[32'h12C >> 2] = enc_r(7'h00, 5, 1, 3'b111, 7);       ex_fetch(32'h12C, 4, -1);
        mem[32'h130 >> 2] = enc_r(7'h00, 4, 1, 3'b110, 8);       ex_fetch(32'h130, 4, 4'b0000);
        mem[32'h134 >> 2] = enc_r(7'h00, 4, 1, 3'b100, 9);       ex_fetch(32'h134, 4, 4'b1000);
        mem[32'h138 >> 2] = enc_r(7'h00, 1, 4, 3'b010, 10);      ex_fetch(32'h138, 4, 4'b1000);
        mem[32'h13C >> 2] = enc_s(12'd24, 7, 0);                 ex_fetch(32'h13C, 4, 4'b1010);
        ex_mem(1'b1, 32'd24, 32'h0000_07FE, 0);
        mem[32'h140 >> 2] = enc_s(12'd28, 8, 0);                 ex_fetch(32'h140, 4, -1);
        ex_mem(1'b1, 32'd28, 32'hFFFF_FFFF, 0);
        mem[32'h144 >> 2] = enc_s(12'd32, 9, 0);                 ex_fetch(32'h144, 4, -1);
        ex_mem(1'b1, 32'd32, 32'hFFFF_F800, 0);
        mem[32'h148 >> 2] = enc_s(12'd36, 10, 0);                ex_fetch(32'h148, 4, -1);
        ex_mem(1'b1, 32'd36, 32'h0000_0001, 0);
        mem[32'h14C >> 2] = 32'h0000_0073;                       ex_fetch(32'h14C, 4, 4'b1010);
        release_rst();
        wait_empty(400);
        chk("ecall_decode_halt", halt, 0);
        tick();
        chk("ecall_halt", halt, 1);
        for (int i = 0; i < 5; i++) begin
            chk("halt_req", mem_req, 0);
            chk("halt_pc", pc, 32'h14C);
            tick();
        end

        // Branches taken / not taken and a branch-to-self loop
        reset_on();
        chk("rst_clears_halt", halt, 0);
        chk("rst_clears_status", status, 0);
        mem[32'h100 >> 2] = enc_i(12'd3, 0, 3'b000, 1, 7'h13); ex_fetch(32'h100, 0, -1);
        mem[32'h104 >> 2] = enc_b(13'h0FC, 3'b000, 0, 0);      ex_fetch(32'h104, 4, 4'b0000);
        mem[32'h200 >> 2] = enc_b(13'd16, 3'b000, 1, 1);       ex_fetch(32'h200, 3, 4'b0110);
        mem[32'h210 >> 2] = enc_b(13'd16, 3'b001, 1, 1);       ex_fetch(32'h210, 3, 4'b0110);
        mem[32'h214 >> 2] = enc_b(13'd8, 3'b001, 0, 1);        ex_fetch(32'h214, 3, 4'b0110);
        mem[32'h21C >> 2] = enc_b(13'd0, 3'b000, 0, 0);        ex_fetch(32'h21C, 3, 4'b0010);
        ex_fetch(32'h21C, 3, 4'b0110);
        ex_fetch(32'h21C, 3, 4'b0110);
        release_rst();
        wait_empty(200);
        strict = 1'b0;
        chk("loop_halt", halt, 0);
        chk("loop_pc", pc, 32'h21C);

        // Reset asserted during a stalled store aborts it
        reset_on();
        mem[10] = 32'hDEAD_BEEF;
        mem[32'h100 >> 2] = enc_i(12'h055, 0, 3'b000, 1, 7'h13); ex_fetch(32'h100, 0, -1);
        mem[32'h104 >> 2] = enc_s(12'd40, 1, 0);                 ex_fetch(32'h104, 4, -1);
        ex_mem(1'b1, 32'd40, 32'h55, 1000);
        release_rst();
        n = 0;
        while (!(mem_req && mem_we) && n < 100) begin
            tick();
            n++;
        end
        chk("st_wait_seen", mem_we, 1);
        chk("st_wait_addr", mem_addr, 32'd40);
        chk("st_wait_wdata", mem_wdata, 32'h55);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("abort_req", mem_req, 0);
        chk("abort_we", mem_we, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_pc", pc, RPC);
        tick();
        chk("abort_no_write", mem[10], 32'hDEAD_BEEF);

        // Register index beyond NREG is illegal
        reset_on();
        mem[32'h100 >> 2] = enc_i(12'd1, 0, 3'b000, 17, 7'h13); ex_fetch(32'h100, 0, -1);
        release_rst();
        wait_empty(20);
        chk("badreg_decode_halt", halt, 0);
        tick();
        chk("badreg_halt", halt, 1);
        chk("badreg_req", mem_req, 0);
        chk("badreg_pc", pc, RPC);
        chk("badreg_status", status, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mc_datapath.md
# mc_datapath

Parametrised multi-cycle successor to the single-cycle RISC-V datapath. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB on one shared memory port with a ready handshake, so the block tolerates wait-state memory. Control is generated internally from the fetched instruction rather than driven by external control lines. It sits between the top level and a unified instruction/data RAM, and exports ALU status and a sticky halt.

## Interface

Parameters:
- XLEN, 32: data/address width; legal values 32 or 64; immediates sign-extend to XLEN.
- NREG, 32: register count; power of 2, 2..32; x0 hard-wired zero.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = store, 0 = load/fetch.
- mem_addr  out  XLEN  byte address.
- mem_wdata  out  XLEN  store data.
- mem_rdata  in  XLEN  load/fetch data; instruction is bits [31:0].
- mem_ready  in  1  transaction completes in any cycle where mem_req && mem_ready.
- status  out  4  {N,Z,C,V} from the last ALU operation.
- pc  out  XLEN  current instruction address.
- halt  out  1  sticky; set on ECALL/illegal instruction.

## Operation

- Supported ops:
  - R-type (0x33): ADD, SUB, AND, OR, XOR, SLT.
  - ADDI (0x13, funct3 000).
  - LW (0x03, funct3 010): XLEN-bit load.
  - SW (0x23, funct3 010): XLEN-bit store.
  - BEQ and BNE (0x63).
  - ECALL (0x73).
- Any other encoding, or any rs1/rs2/rd index >= NREG, is illegal and enters HALT.
- FSM states:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc; hold until mem_ready, then latch IR and go to DECODE.
  - DECODE: latch A=reg[rs1], B=reg[rs2] and the immediate (I, S or B format); go to EXEC, or to HALT if illegal/ECALL.
  - EXEC, R/ADDI: compute the result, update status, go to WB.
  - EXEC, LW/SW: compute addr=A+imm (status unchanged), go to MEM.
  - EXEC, branch: compute A−B and update status; pc ← pc+imm if taken, else pc+4; go to FETCH.
  - MEM: mem_req=1, mem_we=(SW), mem_addr=addr, mem_wdata=B; hold until mem_ready. SW: pc+=4, go to FETCH. LW: latch mem_rdata into MDR, go to WB.
  - WB: reg[rd] ← result or MDR (write ignored when rd=0); pc+=4; go to FETCH.
  - HALT: absorbing state; halt=1, mem_req=0, pc frozen; exited only by reset.
- ALU and status:
  - Arithmetic is modulo 2^XLEN.
  - C = carry-out for ADD; C = NOT borrow for SUB/compare.
  - V = signed overflow.
  - N = result MSB; Z = (result==0).
  - SLT result is 1 or 0, with flags taken from the underlying subtraction.
  - Logic ops set C=V=0.
- mem_addr and mem_wdata are don't-care while mem_req=0, but are driven as 0.

## Timing

- Reset (rst low, asynchronous):
  - pc=RESET_PC, state=FETCH, all registers 0, status=0, halt=0.
  - mem_req, mem_we, mem_addr and mem_wdata are held at 0 while rst is low.
- First mem_req assertion is in the first clk cycle after rst deasserts.
- Cycles per instruction with zero-wait memory (mem_ready high in the request cycle): R/ADDI 4, LW 5, SW 4, branch 3, ECALL/illegal 2 then HALT.
- Each wait cycle (mem_req && !mem_ready) adds 1 cycle.
- While waiting, mem_req, mem_we, mem_addr and mem_wdata are held stable.
- Register writes take effect at the WB clock edge and are visible to the next instruction's DECODE.
- pc changes only at branch-EXEC, SW-MEM completion, or the WB edge.
- Reset asserted mid-transaction aborts it immediately (mem_req drops asynchronously); no register or PC update occurs.
- Branch to the same address (offset 0) is legal and loops forever; it is not a halt.

## Test plan

- Reset/boot: RESET_PC=0x100; hold rst low 2 cycles, release → next cycle mem_req=1, mem_addr=0x100, mem_we=0; halt=0, status=0.
- Arithmetic: ADDI x1,x0,0x7FF; ADD x2,x1,x1 → x2=0xFFE, 4 cycles each. SUB x3,x0,x0 → Z=1, C=1. ADDI x4,x0,-1 then ADD x5,x4,x4 → x5=0xFFFFFFFE, N=1, C=1, V=0 (XLEN=32).
- Memory with waits: SW x2,8(x0) with mem_ready low 3 cycles → addr=8, wdata=0xFFE held for 4 cycles, pc+=4. LW x6,8(x0) → x6=0xFFE; total 8 cycles with the waits.
- Branches: BEQ x1,x1,+16 at pc=0x200 → pc=0x210 after 3 cycles. BNE x1,x1,+16 → pc=0x204.
- x0 and halt: ADDI x0,x0,5 → x0 reads 0. ECALL → halt=1, mem_req=0 indefinitely. With NREG=16, rd=17 → halt.
- Reset mid-op: assert rst during MEM wait of SW → mem_req=0 immediately, memory not written, pc=RESET_PC after release.
